// File: rtl/ad_serial_rx_pkg.sv
// ad_serial_rx_pkg: state encodings and default frame constants shared by the
// AD7276 serial front end, the channel mux and the bench ADC model.
`default_nettype none
package ad_serial_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_QUIET = 2'd3
  } ad_state_t;

  localparam int AD_FRAME_BITS = 16;
  localparam int AD_DATA_W     = 12;
  localparam int AD_LEAD_BITS  = 2;
  localparam int AD_SCLK_DIV   = 2;
  localparam int AD_QUIET_CYC  = 4;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int ad_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ad_sclk_gen.sv
// ad_sclk_gen: half-period counter producing the idle-high ADC serial clock
// plus rise/fall strobes flagging the edge at which sclk will toggle.
`default_nettype none
module ad_sclk_gen
  import ad_serial_rx_pkg::*;
#(
  parameter int SCLK_DIV = AD_SCLK_DIV
) (
  input  logic mclk0,
  input  logic hrst,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int            CW       = ad_cnt_w(SCLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          phase_end;

  // Strobes are deliberately not gated by en so the FSM can use them to
  // decide en without forming a combinational loop.
  assign phase_end = (cnt == CNT_LAST);
  assign rise      = phase_end & ~sclk;
  assign fall      = phase_end & sclk;

  always_ff @(posedge mclk0 or posedge hrst) begin
    if (hrst) begin
      cnt  <= '0;
      sclk <= 1'b1;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b1;
    end else if (phase_end) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ad_serial_rx.sv
// ad_serial_rx: AD7276-class ADC serial receiver (cs_n/sclk/sdata -> 12-bit result).
// Optional leading-zero frame check enabled by defining AD_LEAD_ZERO_CHK_EN.
`default_nettype none
module ad_serial_rx
  import ad_serial_rx_pkg::*;
#(
  parameter int SCLK_DIV   = AD_SCLK_DIV,
  parameter int FRAME_BITS = AD_FRAME_BITS,
  parameter int DATA_W     = AD_DATA_W,
  parameter int LEAD_BITS  = AD_LEAD_BITS,
  parameter int QUIET_CYC  = AD_QUIET_CYC
) (
  input  logic              mclk0,
  input  logic              hrst,
  input  logic              start,
  output logic              busy,
  output logic              cs_n,
  output logic              sclk,
  input  logic              sdata,
  output logic [DATA_W-1:0] data,
  output logic              data_vld,
  output logic              frame_err
);

  localparam int            BW         = ad_cnt_w(FRAME_BITS);
  localparam int            QW         = ad_cnt_w(QUIET_CYC);
  localparam int            RES_MSB    = FRAME_BITS - 1 - LEAD_BITS;
  localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);
  localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYC - 1);

  ad_state_t             state;
  ad_state_t             state_nxt;
  logic [BW-1:0]         bit_cnt;
  logic [QW-1:0]         quiet_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  sclk_en;
  logic                  sclk_rise;
  logic                  sclk_fall;
  logic                  frame_done;
  logic                  lead_err;
  logic                  unused_shreg;

  ad_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk_gen (
    .mclk0 (mclk0),
    .hrst  (hrst),
    .en    (sclk_en),
    .sclk  (sclk),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

`ifdef AD_LEAD_ZERO_CHK_EN
  assign lead_err = |shreg[FRAME_BITS-1 -: LEAD_BITS];
`else
  assign lead_err = 1'b0;
`endif

  // Trailing (and, without the check, leading) frame bits are dropped.
  assign unused_shreg = ^shreg;

  always_ff @(posedge mclk0 or posedge hrst) begin
    if (hrst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    sclk_en    = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        sclk_en = 1'b1;
        if (sclk_fall) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        // Stop the clock generator on the last fall so sclk parks high.
        frame_done = sclk_fall && (bit_cnt == BIT_LAST);
        sclk_en    = !frame_done;
        if (frame_done) state_nxt = ST_QUIET;
      end
      ST_QUIET: begin
        if (quiet_cnt == QUIET_LAST) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk0 or posedge hrst) begin
    if (hrst) begin
      bit_cnt   <= '0;
      quiet_cnt <= '0;
      shreg     <= '0;
    end else begin
      if (state == ST_SHIFT) begin
        if (sclk_rise) shreg <= {shreg[FRAME_BITS-2:0], sdata};
        if (sclk_fall) bit_cnt <= bit_cnt + BW'(1);
      end else begin
        bit_cnt <= '0;
      end
      if (state == ST_QUIET) quiet_cnt <= quiet_cnt + QW'(1);
      else                   quiet_cnt <= '0;
    end
  end

  always_ff @(posedge mclk0 or posedge hrst) begin
    if (hrst) begin
      busy      <= 1'b0;
      cs_n      <= 1'b1;
      data      <= '0;
      data_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      busy      <= (state_nxt != ST_IDLE);
      cs_n      <= !((state_nxt == ST_SETUP) || (state_nxt == ST_SHIFT));
      data_vld  <= frame_done && !lead_err;
      frame_err <= frame_done && lead_err;
      if (frame_done && !lead_err) data <= shreg[RES_MSB -: DATA_W];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ad_serial_rx.sv
// tb_ad_serial_rx: directed + randomized bench for ad_serial_rx with a
// behavioural ADC model and frame-level reference model.
`default_nettype none
module tb_ad_serial_rx;
  import ad_serial_rx_pkg::*;

  localparam int DIV    = AD_SCLK_DIV;
  localparam int FB     = AD_FRAME_BITS;
  localparam int DW     = AD_DATA_W;
  localparam int LB     = AD_LEAD_BITS;
  localparam int QC     = AD_QUIET_CYC;
  localparam int LAT    = 1 + DIV + 2 * DIV * FB;
  localparam int PERIOD = LAT + QC;

  logic          mclk0 = 1'b0;
  logic          hrst;
  logic          start;
  logic          sdata;
  logic          busy;
  logic          cs_n;
  logic          sclk;
  logic [DW-1:0] data;
  logic          data_vld;
  logic          frame_err;

  ad_serial_rx #(
    .SCLK_DIV(DIV), .FRAME_BITS(FB), .DATA_W(DW), .LEAD_BITS(LB), .QUIET_CYC(QC)
  ) dut (
    .mclk0(mclk0), .hrst(hrst), .start(start), .busy(busy), .cs_n(cs_n),
    .sclk(sclk), .sdata(sdata), .data(data), .data_vld(data_vld), .frame_err(frame_err)
  );

  always #5 mclk0 = ~mclk0;

  int cyc = 0;
  always @(posedge mclk0) cyc <= cyc + 1;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            t0      = 0;
  int            rises   = 0;
  logic [FB-1:0] adc_frame = '0;
  logic [DW-1:0] exp_data  = '0;

  // ADC model: bit k is presented from cs_n fall / previous sclk rise until its own rise.
  initial begin
    sdata = 1'b0;
    forever begin
      @(negedge cs_n);
      for (int k = 0; k < FB; k++) begin
        sdata = adc_frame[FB-1-k];
        @(posedge sclk or posedge cs_n);
        if (cs_n) break;
        rises++;
        #1;
      end
    end
  end

  function automatic logic [DW-1:0] ref_data(input logic [FB-1:0] f);
    return DW'(f >> (FB - LB - DW));
  endfunction

  function automatic bit ref_lead_err(input logic [FB-1:0] f);
    return (f >> (FB - LB)) != '0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [FB-1:0] f);
    adc_frame = f;
    rises     = 0;
    @(negedge mclk0);
    start = 1'b1;
    t0    = cyc;
    @(negedge mclk0);
    start = 1'b0;
  endtask

  task automatic wait_result(output int lat, output bit gv, output bit ge);
    lat = -1; gv = 1'b0; ge = 1'b0;
    for (int i = 0; i < LAT + 20; i++) begin
      if (data_vld || frame_err) begin
        gv  = data_vld;
        ge  = frame_err;
        lat = cyc - t0;
        break;
      end
      @(negedge mclk0);
    end
  endtask

  task automatic wait_idle(output int at);
    at = -1;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      if (!busy) begin
        at = cyc - t0;
        break;
      end
      @(negedge mclk0);
    end
  endtask

  task automatic check_frame(input logic [FB-1:0] f, input string tag);
    int lat;
    int at;
    bit gv;
    bit ge;
    bit eerr;
    eerr = 1'b0;
`ifdef AD_LEAD_ZERO_CHK_EN
    eerr = ref_lead_err(f);
`endif
    if (!eerr) exp_data = ref_data(f);
    launch(f);
    wait_result(lat, gv, ge);
    check({tag, " latency"}, lat, LAT);
    check({tag, " data_vld"}, {31'd0, gv}, {31'd0, !eerr});
    check({tag, " frame_err"}, {31'd0, ge}, {31'd0, eerr});
    check({tag, " data"}, {20'd0, data}, {20'd0, exp_data});
    check({tag, " sclk_rises"}, rises, FB);
    check({tag, " cs_n_at_result"}, {31'd0, cs_n}, 32'd1);
    @(negedge mclk0);
    check({tag, " pulse_width"}, {30'd0, data_vld, frame_err}, 32'd0);
    wait_idle(at);
    check({tag, " idle_cycle"}, at, PERIOD);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [FB-1:0] f;
    int            nv;
    int            run;
    int            minrun;
    bit            seen_low;
    int            vcyc [3];
    int            at;

    hrst  = 1'b0;
    start = 1'b0;
    #1 hrst = 1'b1;
    repeat (3) @(negedge mclk0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst cs_n", {31'd0, cs_n}, 32'd1);
    check("rst sclk", {31'd0, sclk}, 32'd1);
    check("rst data", {20'd0, data}, 32'd0);
    check("rst data_vld", {31'd0, data_vld}, 32'd0);
    check("rst frame_err", {31'd0, frame_err}, 32'd0);
    hrst = 1'b0;
    repeat (2) @(negedge mclk0);

    // 0x0ABC framed as 00_1010_1011_1100_00
    check_frame(16'h2AF0, "abc");

    for (int i = 0; i < 8; i++) begin
      f = FB'($urandom());
      if (i % 2 == 0) f[FB-1 -: LB] = '0;
      check_frame(f, $sformatf("rand%0d", i));
    end

    // start while busy is ignored
    f = FB'($urandom());
    f[FB-1 -: LB] = '0;
    exp_data = ref_data(f);
    launch(f);
    while (cyc < t0 + 20) @(negedge mclk0);
    start = 1'b1;
    @(negedge mclk0);
    start = 1'b0;
    nv = 0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge mclk0);
      if (data_vld) nv++;
    end
    check("busy_start vld_count", nv, 1);
    check("busy_start data", {20'd0, data}, {20'd0, exp_data});
    check("busy_start busy", {31'd0, busy}, 32'd0);

    // start held high: back-to-back frames
    f = FB'($urandom());
    f[FB-1 -: LB] = '0;
    exp_data = ref_data(f);
    adc_frame = f;
    @(negedge mclk0);
    start = 1'b1;
    t0 = cyc;
    nv = 0; run = 0; minrun = 1000; seen_low = 1'b0;
    vcyc[0] = 0; vcyc[1] = 0; vcyc[2] = 0;
    for (int i = 0; i < 3 * PERIOD + 10 && nv < 3; i++) begin
      @(negedge mclk0);
      if (data_vld) begin
        vcyc[nv] = cyc;
        nv++;
      end
      if (cs_n) run++;
      else begin
        if (seen_low && run > 0 && run < minrun) minrun = run;
        seen_low = 1'b1;
        run = 0;
      end
    end
    start = 1'b0;
    check("cont vld_count", nv, 3);
    check("cont first_latency", vcyc[0] - t0, LAT);
    check("cont period01", vcyc[1] - vcyc[0], PERIOD);
    check("cont period12", vcyc[2] - vcyc[1], PERIOD);
    check("cont quiet_min", {31'd0, (minrun >= QC && minrun < 1000)}, 32'd1);
    check("cont data", {20'd0, data}, {20'd0, exp_data});
    wait_idle(at);
    check("cont idle", {31'd0, (at >= 0)}, 32'd1);

    // reset in the middle of SHIFT drops the frame
    launch(16'h2AF0);
    while (cyc < t0 + 30) @(negedge mclk0);
    hrst = 1'b1;
    @(negedge mclk0);
    check("midrst cs_n", {31'd0, cs_n}, 32'd1);
    check("midrst sclk", {31'd0, sclk}, 32'd1);
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst data", {20'd0, data}, 32'd0);
    hrst = 1'b0;
    exp_data = '0;
    nv = 0;
    for (int i = 0; i < LAT + 10; i++) begin
      @(negedge mclk0);
      if (data_vld || frame_err) nv++;
    end
    check("midrst no_pulse", nv, 0);
    check_frame(16'h2AF0, "after_rst");

    // leading-one frame: frame_err with check, zero result without
    check_frame(16'hC000, "lead_c000");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
